// File: rtl/pipe_stage_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush-to-bubble and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready (breaks the out_ready->in_ready path).
module pipe_stage_reg #(
  parameter int unsigned          DATA_W = 64,
  parameter logic [DATA_W-1:0]    BUBBLE = '0,
  parameter int unsigned          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              accept;
  logic              drain;
  logic              main_valid_d;
  logic [DATA_W-1:0] main_data_d;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_valid_d;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_d;

  // Ready depends only on the skid register (plus the reset/flush blanking).
  assign in_ready = !skid_valid && !flush && !rst;
`else
  assign in_ready = !flush && !rst && (!out_valid || out_ready);
`endif

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Next-state for main (and skid) entries; flush wins over any handshake.
  always_comb begin
    main_valid_d = out_valid;
    main_data_d  = out_data;
`ifdef PIPE_STAGE_SKID_EN
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
`endif
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      if (skid_valid) begin
        // Skid full implies main full; promote on drain.
        if (drain) begin
          main_data_d  = skid_data;
          skid_valid_d = 1'b0;
        end
      end else if (accept && out_valid && !drain) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
`else
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
      stall_cnt <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid <= 1'b0;
`endif
    end else begin
      out_valid <= main_valid_d;
      out_data  <= main_data_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid <= skid_valid_d;
`endif
      // Back-pressure counter saturates instead of wrapping and survives flush.
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk) begin
    skid_data <= skid_data_d;
  end
`endif

endmodule
